// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions: instruction bus widths and the imem arbiter owner encoding.
package cpu_pkg;
  localparam int IADDRWIDTH = 16;
  localparam int IWIDTH     = 16;

  typedef enum logic {
    OWN_CPU  = 1'b0,
    OWN_HOST = 1'b1
  } arb_owner_t;
endpackage

// File: rtl/imem_arb_burst_ctr.sv
// Host burst limiter: counts consecutive host grants taken while the cpu is waiting and
// withdraws host priority once the limit is reached.
module imem_arb_burst_ctr #(
  parameter int HOST_MAX_BURST = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic cpu_req,
  input  logic host_valid,
  input  logic grant_cpu,
  input  logic grant_host,
  output logic host_allowed
);
  localparam logic [3:0] LIMIT = 4'(HOST_MAX_BURST);

  logic [3:0] burst_cnt;

  assign host_allowed = (burst_cnt < LIMIT);

  // A host grant under contention only happens while burst_cnt < LIMIT, so the count tops out at LIMIT.
  always_ff @(posedge clk) begin
    if (rst)                        burst_cnt <= '0;
    else if (grant_cpu || !host_valid) burst_cnt <= '0;
    else if (grant_host && cpu_req) burst_cnt <= burst_cnt + 4'd1;
  end
endmodule

// File: rtl/imem_arbiter.sv
// Single-port instruction memory arbiter between cpu fetch and a host loader/debug port.
// Optional IMEM_ARB_STATS_EN adds stall / host-grant statistics counters with stat_clr.
module imem_arbiter
  import cpu_pkg::*;
#(
  parameter int AW             = IADDRWIDTH,
  parameter int DW             = IWIDTH,
  parameter int HOST_MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic [AW-1:0] cpu_addr,
  output logic          cpu_stall,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          host_valid,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_ready,
  output logic          host_rvalid,
  output logic [DW-1:0] host_rdata,
`ifdef IMEM_ARB_STATS_EN
  input  logic          stat_clr,
  output logic [31:0]   stat_cpu_stalls,
  output logic [31:0]   stat_host_grants,
`endif
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);
  logic       grant_cpu, grant_host, host_allowed;
  logic       rd_pend;
  arb_owner_t owner;

  assign grant_host = !rst && host_valid && (!cpu_req || host_allowed);
  assign grant_cpu  = !rst && cpu_req && !grant_host;

  imem_arb_burst_ctr #(.HOST_MAX_BURST(HOST_MAX_BURST)) u_burst (
    .clk          (clk),
    .rst          (rst),
    .cpu_req      (cpu_req),
    .host_valid   (host_valid),
    .grant_cpu    (grant_cpu),
    .grant_host   (grant_host),
    .host_allowed (host_allowed)
  );

  assign host_ready = grant_host;
  assign cpu_stall  = cpu_req && !grant_cpu;
  assign mem_en     = grant_cpu || grant_host;
  assign mem_we     = grant_host && host_we;
  assign mem_addr   = grant_host ? host_addr  : cpu_addr;
  assign mem_wdata  = grant_host ? host_wdata : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      owner   <= OWN_CPU;
      rd_pend <= 1'b0;
    end else begin
      rd_pend <= grant_cpu || (grant_host && !host_we);
      if (grant_host)     owner <= OWN_HOST;
      else if (grant_cpu) owner <= OWN_CPU;
    end
  end

  // Gating with rst drops a read already in flight when reset is raised.
  assign cpu_rvalid  = rd_pend && !rst && (owner == OWN_CPU);
  assign host_rvalid = rd_pend && !rst && (owner == OWN_HOST);
  assign cpu_rdata   = mem_rdata;
  assign host_rdata  = mem_rdata;

`ifdef IMEM_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      stat_cpu_stalls  <= '0;
      stat_host_grants <= '0;
    end else begin
      if (cpu_stall && (stat_cpu_stalls != '1))   stat_cpu_stalls  <= stat_cpu_stalls + 32'd1;
      if (grant_host && (stat_host_grants != '1)) stat_host_grants <= stat_host_grants + 32'd1;
    end
  end
`endif
endmodule
